// File: rtl/adsr.sv
// ADSR envelope generator with linear ramps in a wide accumulator; env is Q2.14.
// Optional ADSR_HARD_RETRIG_EN: note-on restarts the attack from silence.
module adsr #(
  parameter int ACC_WIDTH = 32,
  parameter int SUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 stop,
  input  logic [ACC_WIDTH-1:0] attack_step,
  input  logic [ACC_WIDTH-1:0] decay_step,
  input  logic [15:0]          sustain_level,
  input  logic [SUS_WIDTH-1:0] sustain_time,
  input  logic [ACC_WIDTH-1:0] release_step,
  output logic [15:0]          env,
  output logic                 env_valid,
  output logic                 idle
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  localparam logic [ACC_WIDTH-1:0] MAX =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [2:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [SUS_WIDTH-1:0] r_cnt;
  logic                 r_vld;

  logic [2:0]           w_state_n;
  logic [ACC_WIDTH-1:0] w_acc_n;
  logic [SUS_WIDTH-1:0] w_cnt_n;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH:0]   w_asum;
  logic [ACC_WIDTH:0]   w_ddif;
  logic [SUS_WIDTH:0]   w_cinc;
  logic [14:0]          w_lvl;
  logic [ACC_WIDTH-1:0] w_sus;
  logic                 w_a_top;
  logic                 w_d_bot;
  logic                 w_s_end;
  logic                 w_s_hold;
  logic                 w_busy;

  always_comb begin
    w_base = r_acc;
`ifdef ADSR_HARD_RETRIG_EN
    if (start) w_base = '0;
`endif
    w_lvl    = (sustain_level > 16'h4000) ? 15'h4000
                                          : sustain_level[14:0];
    w_sus    = {w_lvl, {(ACC_WIDTH-15){1'b0}}};
    w_asum   = {1'b0, w_base} + {1'b0, attack_step};
    w_a_top  = w_asum >= {1'b0, MAX};
    w_ddif   = {1'b0, r_acc} - {1'b0, decay_step};
    w_d_bot  = w_ddif[ACC_WIDTH]
            || (w_ddif[ACC_WIDTH-1:0] <= w_sus);
    w_cinc   = {1'b0, r_cnt} + {{SUS_WIDTH{1'b0}}, 1'b1};
    w_s_hold = &sustain_time;
    // >= rather than == so a shortened hold time still terminates
    w_s_end  = w_cinc >= {1'b0, sustain_time};
    w_busy   = (r_state == S_ATK) || (r_state == S_DEC)
            || (r_state == S_SUS);
  end

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_cnt_n   = r_cnt;
    if (start) begin
      w_state_n = S_ATK;
      w_cnt_n   = '0;
      w_acc_n   = w_base;
      if (en) begin
        if (w_a_top) begin
          w_acc_n   = MAX;
          w_state_n = S_DEC;
        end else begin
          w_acc_n = w_asum[ACC_WIDTH-1:0];
        end
      end
    end else if (stop && w_busy) begin
      w_state_n = S_REL;
    end else if (en) begin
      unique case (r_state)
        S_ATK: begin
          if (w_a_top) begin
            w_acc_n   = MAX;
            w_state_n = S_DEC;
          end else begin
            w_acc_n = w_asum[ACC_WIDTH-1:0];
          end
        end
        S_DEC: begin
          if (w_d_bot) begin
            w_acc_n   = w_sus;
            w_state_n = S_SUS;
          end else begin
            w_acc_n = w_ddif[ACC_WIDTH-1:0];
          end
        end
        S_SUS: begin
          w_acc_n = w_sus;
          if (!w_s_hold) begin
            w_cnt_n = w_cinc[SUS_WIDTH-1:0];
            if (w_s_end) w_state_n = S_REL;
          end
        end
        S_REL: begin
          if (r_acc <= release_step) begin
            w_acc_n   = '0;
            w_state_n = S_IDLE;
          end else begin
            w_acc_n = r_acc - release_step;
          end
        end
        default: begin
          w_acc_n = r_acc;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_cnt   <= w_cnt_n;
      r_vld   <= en;
    end
  end

  assign env       = {1'b0, r_acc[ACC_WIDTH-1 -: 15]};
  assign env_valid = r_vld;
  assign idle      = (r_state == S_IDLE);

endmodule

// File: tb/tb_adsr.sv
// Directed bench for adsr: expected env values queued per tick,
// popped and checked on the cycle after each sample strobe.
module tb_adsr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        start;
  logic        stop;
  logic [31:0] attack_step;
  logic [31:0] decay_step;
  logic [15:0] sustain_level;
  logic [31:0] sustain_time;
  logic [31:0] release_step;
  logic [15:0] env;
  logic        env_valid;
  logic        idle;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];
  logic [15:0] m;

  adsr dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en),
    .start         (start),
    .stop          (stop),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .sustain_time  (sustain_time),
    .release_step  (release_step),
    .env           (env),
    .env_valid     (env_valid),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [15:0] e);
    sb.push_back(e);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk("valid_hi", {15'b0, env_valid}, 16'h0001);
    chk("env", env, sb.pop_front());
    @(posedge clk); #1;
    chk("valid_lo", {15'b0, env_valid}, 16'h0000);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic ev(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic fall_to_zero(input logic [15:0] from);
    logic [15:0] v;
    v = from;
    while (v != 16'h0000) begin
      v = (v > 16'h0800) ? v - 16'h0800 : 16'h0000;
      tick(v);
    end
    chk("idle_end", {15'b0, idle}, 16'h0001);
  endtask

  initial begin
    reset_n       = 1'b0;
    en            = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    attack_step   = 32'h1000_0000;
    decay_step    = 32'h0800_0000;
    sustain_level = 16'h2000;
    sustain_time  = 32'd3;
    release_step  = 32'h1000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", env, 16'h0000);
    chk("rst_valid", {15'b0, env_valid}, 16'h0000);
    chk("rst_idle", {15'b0, idle}, 16'h0001);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // full note
    ev(1'b1, 1'b0);
    chk("atk_busy", {15'b0, idle}, 16'h0000);
    for (int i = 1; i <= 8; i++) tick(16'(i * 16'h0800));
    for (int i = 1; i <= 8; i++) tick(16'h4000 - 16'(i * 16'h0400));
    for (int i = 0; i < 3; i++) tick(16'h2000);
    chk("sus_busy", {15'b0, idle}, 16'h0000);
    tick(16'h1800);
    tick(16'h1000);
    tick(16'h0800);
    tick(16'h0000);
    chk("rel_idle", {15'b0, idle}, 16'h0001);

    // early stop during attack
    ev(1'b1, 1'b0);
    tick(16'h0800);
    tick(16'h1000);
    tick(16'h1800);
    ev(1'b0, 1'b1);
    fall_to_zero(16'h1800);

    // retrigger from an indefinitely held sustain
    sustain_time = 32'hFFFF_FFFF;
    ev(1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) tick(16'(i * 16'h0800));
    for (int i = 1; i <= 8; i++) tick(16'h4000 - 16'(i * 16'h0400));
    for (int i = 0; i < 5; i++) tick(16'h2000);
    ev(1'b1, 1'b0);
`ifdef ADSR_HARD_RETRIG_EN
    m = 16'h0800;
`else
    m = 16'h2800;
`endif
    tick(m);
    ev(1'b0, 1'b1);
    fall_to_zero(m);

    // start and stop together: start wins
    ev(1'b1, 1'b1);
    chk("ss_busy", {15'b0, idle}, 16'h0000);
    tick(16'h0800);
    tick(16'h1000);
    ev(1'b0, 1'b1);
    fall_to_zero(16'h1000);

    // sustain level above full scale clamps
    sustain_level = 16'h7FFF;
    sustain_time  = 32'd2;
    ev(1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) tick(16'(i * 16'h0800));
    tick(16'h4000);
    tick(16'h4000);
    tick(16'h4000);
    fall_to_zero(16'h4000);

    // reset mid-attack
    sustain_level = 16'h2000;
    ev(1'b1, 1'b0);
    tick(16'h0800);
    tick(16'h1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_env", env, 16'h0000);
    chk("mid_rst_idle", {15'b0, idle}, 16'h0001);
    chk("mid_rst_vld", {15'b0, env_valid}, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tick(16'h0000);
    chk("post_rst_idle", {15'b0, idle}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
